alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Operand/result stage wrapped around the combinational ALU. Buffers ALU requests
//  (A, B, 5-bit op) in a small FIFO and performs the Y-load / execute / Z-capture
//  sequence: latches A into Y, drives Y, B and op onto the ALU, then captures the
//  2*DATA_W result into ZHi/ZLo. Returns each result through a valid/ready response port.
// PARAMETERS
//  DATA_W      32  operand width; the ALU result is 2*DATA_W wide (MUL/DIV hi:lo)
//  OP_W        5   ALU select width (matches ALU in_c)
//  FIFO_DEPTH  2   request buffer entries, power of two, >=2
//  NUM_OPS     16  opcodes 0..NUM_OPS-1 are legal; op 0 = ADD
// PORTS
//  clk        in   1         single clock, rising edge
//  clear      in   1         synchronous, active-high reset
//  req_valid  in   1         request present
//  req_ready  out  1         request accepted when req_valid & req_ready
//  req_a      in   DATA_W    operand A (goes through Y)
//  req_b      in   DATA_W    operand B
//  req_op     in   OP_W      ALU select
//  alu_a      out  DATA_W    to ALU in_a (Y register)
//  alu_b      out  DATA_W    to ALU in_b
//  alu_op     out  OP_W      to ALU in_c
//  alu_res    in   2*DATA_W  from ALU result {hi,lo}
//  alu_cout   in   1         from ALU carry-out
//  rsp_valid  out  1         Z holds a completed result
//  rsp_ready  in   1         consumer takes result when rsp_valid & rsp_ready
//  z_hi       out  DATA_W    ZHi
//  z_lo       out  DATA_W    ZLo
//  z_cout     out  1         captured carry
//  rsp_err    out  1         result produced by an illegal opcode
// BEHAVIOUR
//  Reset (clear=1 at an edge): FIFO emptied, FSM->IDLE, Y/alu_b/alu_op/Z/z_cout/rsp_err=0,
//   rsp_valid=0; req_ready=1 from the first cycle after clear is released.
//  Mid-operation clear: all queued and in-flight requests discarded; no response issued.
//  FIFO: req_ready = !full; push on req_valid&req_ready; no push while full; push and pop
//   in the same cycle allowed at any occupancy (incl. full: pop frees slot next cycle only).
//  FSM states:
//   IDLE : FIFO not empty -> pop head, Y<=a, B reg<=b, op reg<=op; -> EXEC
//   EXEC : alu_a=Y, alu_b=B, alu_op=op driven for this whole cycle; at its end
//          {z_hi,z_lo}<=alu_res, z_cout<=alu_cout, rsp_err<=0; -> HOLD
//          illegal op (op>=NUM_OPS): Z<=0, z_cout<=0, rsp_err<=1 instead
//   HOLD : rsp_valid=1, Z stable; rsp_ready=1 -> IDLE, or directly pop next FIFO entry
//          into Y and -> EXEC (back-to-back); rsp_ready=0 -> stay
//  Latency: request accepted at edge N (empty FIFO, IDLE) -> popped at N+1, ALU driven
//   cycle after N+1, Z captured at N+2, rsp_valid=1 after edge N+2.
//  Throughput with rsp_ready=1: one result per 2 cycles.
//  Outside EXEC, alu_a/alu_b/alu_op hold their last values (no glitching to the ALU).
//  Capacity: FIFO_DEPTH queued + 1 in flight; the next request stalls on req_ready=0.
//  Ordering: responses strictly in request order; no result dropped or duplicated.
//  Z/rsp_err keep their last value after the response is consumed, until next capture.
// TESTING (bench uses a behavioural ALU model: op0 ADD, op1 SUB, op2 MUL)
//  1 ADD: a=5,b=2,op=0, rsp_ready=1 -> rsp_valid 2 edges after accept, z_lo=7, z_hi=0
//  2 SUB wrap: a=0,b=1,op=1 -> z_lo=32'hFFFF_FFFF, z_cout per model, rsp_err=0
//  3 MUL hi word: a=32'h8000_0000,b=4,op=2 -> z_hi=2, z_lo=0
//  4 Backpressure: rsp_ready=0, 4 ADD reqs (1+1..4+4) -> 3 accepted, req_ready=0 on 4th;
//    release rsp_ready -> z_lo=2,4,6,8 in order, 4th accepted once a slot frees
//  5 Illegal op=5'd20, a=9,b=9 -> rsp_valid, z_hi=z_lo=0, rsp_err=1; next ADD clears rsp_err
//  6 clear asserted during EXEC with 2 queued -> no rsp_valid afterwards, all outputs 0,
//    req_ready=1; subsequent ADD 3+4 -> z_lo=7

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand/result stage around a combinational ALU: request FIFO, then Y-load / execute / Z-capture sequencing.
// Latency: a request accepted into an empty FIFO while idle gives rsp_valid two edges later; one result per 2 cycles.
// Backpressure: req_ready drops when the FIFO is full; a stalled response (rsp_ready=0) holds Z and stops popping.
module alu_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_OPS    = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [OP_W-1:0]     req_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [2*DATA_W-1:0] alu_res,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo,
  output logic                z_cout,
  output logic                rsp_err
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Request FIFO: pointers wrap naturally since the depth is a power of two.
  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_push, fifo_pop, fifo_rd_vld;
  req_t             req_dat, head;

  assign req_dat     = '{a: req_a, b: req_b, op: req_op};
  assign req_ready   = (fifo_cnt != CNT_W'(FIFO_DEPTH));
  assign fifo_rd_vld = (fifo_cnt != '0);
  assign fifo_push   = req_valid & req_ready;
  assign head        = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (fifo_pop && !fifo_push) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= req_dat;
  end

  state_t            state_q, state_d;
  logic              load, capture, illegal;
  logic [DATA_W-1:0] y_q, b_q;
  logic [OP_W-1:0]   op_q;

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rd_vld) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // Back-to-back: consume and launch the next operation in one edge.
          if (fifo_rd_vld) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign illegal = ({1'b0, op_q} >= (OP_W+1)'(NUM_OPS));

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      y_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_hi    <= '0;
      z_lo    <= '0;
      z_cout  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        y_q  <= head.a;
        b_q  <= head.b;
        op_q <= head.op;
      end
      if (capture) begin
        if (illegal) begin
          z_hi    <= '0;
          z_lo    <= '0;
          z_cout  <= 1'b0;
          rsp_err <= 1'b1;
        end else begin
          {z_hi, z_lo} <= alu_res;
          z_cout       <= alu_cout;
          rsp_err      <= 1'b0;
        end
      end
    end
  end

  // ALU inputs come straight from registers, so they only change on a load.
  assign alu_a  = y_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

endmodule
